// File: rtl/athena_vbus_pkg.sv
// rtl/athena_vbus_pkg.sv - shared types and widths for the video bus arbiter
package athena_vbus_pkg;

  localparam int VA_W = 13;
  localparam int VD_W = 8;

  // Value driven on the data bus whenever no write strobe is active
  localparam logic [VD_W-1:0] VD_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_LATCH  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/athena_vbus_rr.sv
// rtl/athena_vbus_rr.sv - two-way round-robin winner selection
module athena_vbus_rr
  import athena_vbus_pkg::*;
(
  input  logic   a_req,
  input  logic   b_req,
  input  owner_e last_grant,
  output logic   grant_valid,
  output owner_e grant
);

  // Single requester wins outright; on contention the CPU not granted last wins
  always_comb begin
    grant_valid = a_req | b_req;
    if (a_req && b_req) begin
      grant = (last_grant == OWN_A) ? OWN_B : OWN_A;
    end else if (a_req) begin
      grant = OWN_A;
    end else begin
      grant = OWN_B;
    end
  end

endmodule

// File: rtl/athena_vbus_arbiter.sv
// rtl/athena_vbus_arbiter.sv - two-CPU video bus arbiter driven by video slot windows
module athena_vbus_arbiter
  import athena_vbus_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            slot_cen,
  input  logic            a_req,
  input  logic            b_req,
  input  logic            a_wr,
  input  logic            b_wr,
  input  logic [VA_W-1:0] a_addr,
  input  logic [VA_W-1:0] b_addr,
  input  logic [VD_W-1:0] a_wdata,
  input  logic [VD_W-1:0] b_wdata,
  output logic            a_ack,
  output logic            b_ack,
  output logic [VD_W-1:0] rdata,
  output logic [VA_W-1:0] va,
  output logic [VD_W-1:0] vd_out,
  input  logic [VD_W-1:0] vd_in,
  output logic            vdg_n,
  output logic            vrd_n,
  output logic            vwe_n,
  output logic            ae,
  output logic            be
);

  // Counter value on the final strobe cycle
  localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  owner_e          owner_q, owner_d;
  owner_e          last_grant_q, last_grant_d;
  logic            wr_q, wr_d;
  logic [VA_W-1:0] addr_q, addr_d;
  logic [VD_W-1:0] wdata_q, wdata_d;
  logic [VD_W-1:0] rdata_q, rdata_d;

  logic            grant_valid;
  owner_e          grant;
  logic            capture;
  logic            strobe_done;

  athena_vbus_rr u_rr (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // A window is only taken when it arrives in IDLE with someone asking
  assign capture     = (state_q == ST_IDLE) && slot_cen && grant_valid;
  assign strobe_done = (state_q == ST_STROBE) && (cnt_q == STROBE_LAST);

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> SETUP -> STROBE (n cycles) -> LATCH -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (capture) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: if (strobe_done) state_d = ST_LATCH;
      ST_LATCH:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Access context: captured once in IDLE so later request changes cannot disturb it
  always_comb begin
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    if (capture) begin
      owner_d = grant;
      wr_d    = (grant == OWN_A) ? a_wr    : b_wr;
      addr_d  = (grant == OWN_A) ? a_addr  : b_addr;
      wdata_d = (grant == OWN_A) ? a_wdata : b_wdata;
    end
    if (state_q == ST_SETUP) begin
      cnt_d = 3'd0;
    end
    if (state_q == ST_STROBE) begin
      if (strobe_done) begin
        cnt_d        = 3'd0;
        last_grant_d = owner_q;
        if (!wr_q) begin
          rdata_d = vd_in;
        end
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  // Access context registers; last_grant resets to B so A wins the first contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= 3'd0;
      owner_q      <= OWN_A;
      last_grant_q <= OWN_B;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= VD_IDLE;
      rdata_q      <= VD_IDLE;
    end else begin
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Bus outputs decoded from the current state; va holds the last captured address
  always_comb begin
    va     = addr_q;
    rdata  = rdata_q;
    vd_out = VD_IDLE;
    vdg_n  = 1'b1;
    vrd_n  = 1'b1;
    vwe_n  = 1'b1;
    ae     = 1'b0;
    be     = 1'b0;
    a_ack  = 1'b0;
    b_ack  = 1'b0;
    case (state_q)
      ST_SETUP: begin
        vdg_n = 1'b0;
        ae    = (owner_q == OWN_A);
        be    = (owner_q == OWN_B);
      end
      ST_STROBE: begin
        vdg_n = 1'b0;
        ae    = (owner_q == OWN_A);
        be    = (owner_q == OWN_B);
        if (wr_q) begin
          vwe_n  = 1'b0;
          vd_out = wdata_q;
        end else begin
          vrd_n = 1'b0;
        end
      end
      ST_LATCH: begin
        vdg_n = 1'b0;
        ae    = (owner_q == OWN_A);
        be    = (owner_q == OWN_B);
        a_ack = (owner_q == OWN_A);
        b_ack = (owner_q == OWN_B);
      end
      default: begin
        vdg_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_athena_vbus_arbiter.sv
// tb/tb_athena_vbus_arbiter.sv - randomized bench with behavioural model for three strobe widths
module tb_athena_vbus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slot_cen = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, a_wr = 1'b0, b_wr = 1'b0;
  logic [12:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0, vd_in = '0;

  logic [2:0]  a_ack_w, b_ack_w, vdg_w, vrd_w, vwe_w, ae_w, be_w;
  logic [12:0] va_w [3];
  logic [7:0]  vd_w [3];
  logic [7:0]  rd_w [3];

  int sc [3] = '{2, 1, 7};
  int ncmp = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    athena_vbus_arbiter #(.STROBE_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 7))) u_dut (
      .clk(clk), .reset(rst), .slot_cen(slot_cen),
      .a_req(a_req), .b_req(b_req), .a_wr(a_wr), .b_wr(b_wr),
      .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
      .a_ack(a_ack_w[g]), .b_ack(b_ack_w[g]), .rdata(rd_w[g]), .va(va_w[g]),
      .vd_out(vd_w[g]), .vd_in(vd_in), .vdg_n(vdg_w[g]), .vrd_n(vrd_w[g]),
      .vwe_n(vwe_w[g]), .ae(ae_w[g]), .be(be_w[g])
    );
  end

  // Model: an access is "busy" with t = cycles since the capturing edge.
  // t=1 setup, t=2..S+1 strobe, t=S+2 latch/ack. own: 0 = A, 1 = B.
  bit          m_busy [3];
  int          m_t    [3];
  bit          m_own  [3];
  bit          m_wr   [3];
  bit          m_last [3];
  logic [12:0] m_va   [3];
  logic [7:0]  m_wd   [3];
  logic [7:0]  m_rd   [3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0; m_t[i] <= 0; m_last[i] <= 1'b1;
        m_va[i] <= '0; m_rd[i] <= 8'hFF; m_wr[i] <= 1'b0; m_own[i] <= 1'b0; m_wd[i] <= 8'hFF;
      end else if (m_busy[i]) begin
        if (m_t[i] == sc[i] + 2) begin
          m_busy[i] <= 1'b0;
        end else begin
          if (m_t[i] == sc[i] + 1) begin
            if (!m_wr[i]) m_rd[i] <= vd_in;
            m_last[i] <= m_own[i];
          end
          m_t[i] <= m_t[i] + 1;
        end
      end else if (slot_cen && (a_req || b_req)) begin
        bit w;
        w = (a_req && b_req) ? !m_last[i] : !a_req;
        m_own[i]  <= w;
        m_busy[i] <= 1'b1;
        m_t[i]    <= 1;
        m_wr[i]   <= w ? b_wr : a_wr;
        m_va[i]   <= w ? b_addr : a_addr;
        m_wd[i]   <= w ? b_wdata : a_wdata;
      end
    end
  end

  function automatic logic [35:0] exp_vec(int i);
    bit st, lt, bz;
    bz = m_busy[i];
    st = bz && m_t[i] >= 2 && m_t[i] <= sc[i] + 1;
    lt = bz && m_t[i] == sc[i] + 2;
    return {bz && !m_own[i], bz && m_own[i], lt && !m_own[i], lt && m_own[i],
            !bz, !(st && !m_wr[i]), !(st && m_wr[i]), m_va[i],
            (st && m_wr[i]) ? m_wd[i] : 8'hFF, m_rd[i]};
  endfunction

  function automatic logic [35:0] act_vec(int i);
    return {ae_w[i], be_w[i], a_ack_w[i], b_ack_w[i], vdg_w[i], vrd_w[i], vwe_w[i],
            va_w[i], vd_w[i], rd_w[i]};
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      ncmp++;
      if (act_vec(i) !== exp_vec(i)) begin
        nmis++;
        $display("FAIL model_cmp inst%0d t=%0t got %h want %h", i, $time, act_vec(i), exp_vec(i));
      end
      ncmp++;
      if ((ae_w[i] && be_w[i]) || (a_ack_w[i] && b_ack_w[i])) begin
        nmis++;
        $display("FAIL exclusive inst%0d t=%0t ae/be=%b%b acks=%b%b want no overlap",
                 i, $time, ae_w[i], be_w[i], a_ack_w[i], b_ack_w[i]);
      end
    end
  endtask

  task automatic chk(string nm, int got, int want);
    ncmp++;
    if (got != want) begin
      nmis++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Compare at the negedge, then advance to just after the next rising edge
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input bit is_b, input logic [12:0] ad, input logic [7:0] wd);
    int lat [3];
    int wid [3];
    int exp_lat [3] = '{4, 3, 9};
    int exp_wid [3] = '{2, 1, 7};
    slot_cen = 1'b1;
    tick();
    slot_cen = 1'b0;
    for (int k = 1; k < 12; k++) begin
      if (k == 1) chk("va_setup", int'(va_w[0]), int'(ad));
      for (int i = 0; i < 3; i++) begin
        if ((is_b ? b_ack_w[i] : a_ack_w[i]) && lat[i] == 0) lat[i] = k;
        if (is_b ? (!vwe_w[i] && vd_w[i] == wd) : !vrd_w[i]) wid[i]++;
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ack_latency_inst%0d", i), lat[i], exp_lat[i]);
      chk($sformatf("strobe_width_inst%0d", i), wid[i], exp_wid[i]);
    end
  endtask

  initial begin
    int acks, first_ack, prev_ack;
    bit gap_ok;
    // Reset state
    tick();
    tick();
    chk("reset_rdata", int'(rd_w[0]), 8'hFF);
    chk("reset_va", int'(va_w[0]), 0);
    chk("reset_vdg_n", int'(vdg_w[0]), 1);
    chk("reset_vd_out", int'(vd_w[0]), 8'hFF);
    rst = 1'b0;
    tick();

    // A read of 0x0123 returning 0x5A
    a_req = 1'b1; a_wr = 1'b0; a_addr = 13'h0123; vd_in = 8'h5A;
    run_access(1'b0, 13'h0123, 8'hFF);
    a_req = 1'b0; vd_in = 8'h00;
    for (int i = 0; i < 3; i++) chk($sformatf("rdata_read_inst%0d", i), int'(rd_w[i]), 8'h5A);

    // B write of 0xC3 to 0x1FFF leaves rdata alone
    b_req = 1'b1; b_wr = 1'b1; b_addr = 13'h1FFF; b_wdata = 8'hC3;
    run_access(1'b1, 13'h1FFF, 8'hC3);
    b_req = 1'b0; b_wr = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("rdata_kept_inst%0d", i), int'(rd_w[i]), 8'h5A);

    // Contention after reset: A, B, A
    rst = 1'b1; tick(); rst = 1'b0; tick();
    a_req = 1'b1; b_req = 1'b1;
    for (int n = 0; n < 3; n++) begin
      slot_cen = 1'b1;
      tick();
      slot_cen = 1'b0;
      chk($sformatf("rr_ae_%0d", n), int'(ae_w[0]), (n != 1) ? 1 : 0);
      chk($sformatf("rr_be_%0d", n), int'(be_w[0]), (n == 1) ? 1 : 0);
      repeat (10) tick();
    end
    b_req = 1'b0;

    // Slot every cycle: inst0 completes an access every 5 cycles
    acks = 0; first_ack = -1; prev_ack = -1; gap_ok = 1'b1;
    slot_cen = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (a_ack_w[0]) begin
        acks++;
        if (first_ack < 0) first_ack = k;
        if (prev_ack >= 0 && k - prev_ack != 5) gap_ok = 1'b0;
        prev_ack = k;
      end
      tick();
    end
    slot_cen = 1'b0; a_req = 1'b0;
    chk("back2back_acks", acks, 4);
    chk("back2back_first", first_ack, 4);
    chk("back2back_gap", int'(gap_ok), 1);
    repeat (10) tick();

    // Reset during STROBE
    a_req = 1'b1; slot_cen = 1'b1;
    tick();
    slot_cen = 1'b0;
    tick();
    chk("strobe_active", int'(vrd_w[0]), 0);
    rst = 1'b1;
    #1;
    chk("rst_vrd_n", int'(vrd_w[0]), 1);
    chk("rst_vwe_n", int'(vwe_w[0]), 1);
    chk("rst_ae_be", int'({ae_w[0], be_w[0]}), 0);
    chk("rst_vdg_n", int'(vdg_w[0]), 1);
    tick();
    rst = 1'b0;
    b_req = 1'b1;
    tick();
    slot_cen = 1'b1;
    tick();
    slot_cen = 1'b0;
    chk("post_rst_grant_a", int'(ae_w[0]), 1);
    a_req = 1'b0; b_req = 1'b0;
    repeat (10) tick();

    // Randomized traffic, including drops, mid-access changes and stray resets
    for (int c = 0; c < 3000; c++) begin
      slot_cen = ($urandom_range(0, 2) == 0);
      a_req    = ($urandom_range(0, 1) == 1);
      b_req    = ($urandom_range(0, 1) == 1);
      a_wr     = $urandom_range(0, 1) == 1;
      b_wr     = $urandom_range(0, 1) == 1;
      a_addr   = 13'($urandom);
      b_addr   = 13'($urandom);
      a_wdata  = 8'($urandom);
      b_wdata  = 8'($urandom);
      vd_in    = 8'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule

// File: doc/athena_vbus_arbiter.md
ATHENA_VBUS_ARBITER -- requirements
Module: athena_vbus_arbiter

Interface
REQ-001 STROBE_CYCLES, 2, number of cycles vwe_n/vrd_n strobe is held (legal 1..7).
REQ-002 clk  input  1  system clock (53.6 MHz); all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 slot_cen  input  1  one-cycle pulse from video timing marking a CPU access window.
REQ-005 a_req / b_req  input  1  CPU A / CPU B access request, level, held until ack.
REQ-006 a_wr / b_wr  input  1  1 = write, 0 = read.
REQ-007 a_addr / b_addr  input  13  video address.
REQ-008 a_wdata / b_wdata  input  8  write data.
REQ-009 a_ack / b_ack  output  1  one-cycle completion pulse.
REQ-010 rdata  output  8  read data, valid in the ack cycle and held until the next read completes.
REQ-011 va  output  13  shared video address bus.
REQ-012 vd_out  output  8  shared video write data.
REQ-013 vd_in  input  8  shared video read data.
REQ-014 vdg_n  output  1  bus gate, low while the CPU owns the bus.
REQ-015 vrd_n / vwe_n  output  1  read / write strobes, active low.
REQ-016 ae / be  output  1  CPU A / CPU B owner enables, mutually exclusive.

Function
REQ-017 FSM states: IDLE, SETUP, STROBE, LATCH; all other encodings SHALL return to IDLE.
REQ-018 IDLE: on slot_cen=1 with a_req|b_req, latch winner, addr, wdata, wr; go to SETUP; otherwise stay.
REQ-019 slot_cen outside IDLE, or with no request, SHALL be ignored; no queueing of missed windows.
REQ-020 Arbitration: single requester wins; both requesting -> requester not granted last (round robin).
REQ-021 last_grant SHALL update only when the access reaches LATCH.
REQ-022 SETUP (1 cycle): va = latched addr, vdg_n=0, owner enable high, strobes inactive.
REQ-023 STROBE (STROBE_CYCLES cycles, counted by a 3-bit counter): vwe_n=0 on write, else vrd_n=0; vd_out = latched wdata on write, 8'hFF on read.
REQ-024 LATCH (1 cycle): strobes high, vdg_n still 0; on read, rdata <= vd_in sampled on the last STROBE cycle; winner's ack=1; next state IDLE.
REQ-025 Total latency slot_cen -> ack = 2+STROBE_CYCLES cycles (4 by default).
REQ-026 In IDLE: vdg_n=1, vrd_n=1, vwe_n=1, ae=be=0, va holds last value, vd_out=8'hFF.
REQ-027 Requester dropping req mid-access: access completes unchanged, ack still pulses.
REQ-028 Request inputs changing after the IDLE capture SHALL not affect the access in progress.
REQ-029 slot_cen in the same cycle as LATCH SHALL be ignored (state is not yet IDLE).
REQ-030 ae and be SHALL never both be 1; a_ack and b_ack SHALL never both be 1.

Reset
REQ-031 Reset asserted -> immediate IDLE: vdg_n=vrd_n=vwe_n=1, ae=be=0, a_ack=b_ack=0, va=0, vd_out=8'hFF, rdata=8'hFF, counter=0, last_grant=B (CPU A wins first contention).
REQ-032 Reset mid-access SHALL abort it with no ack pulse; first slot_cen after release starts arbitration fresh.

Structure
REQ-033 Shared package athena_vbus_pkg SHALL hold the state enum, owner enum (OWN_A, OWN_B), VA_W=13 and VD_W=8.
REQ-034 Round-robin winner selection SHALL be the sub-module athena_vbus_rr (combinational: a_req, b_req, last_grant -> grant_valid, grant).

Verification
REQ-035 A read only, addr 0x0123, vd_in=0x5A -> va=0x0123 from SETUP, vrd_n low 2 cycles, a_ack 4 cycles after slot_cen, rdata=0x5A.
REQ-036 B write, addr 0x1FFF, data 0xC3 -> be=1, vwe_n low 2 cycles with vd_out=0xC3, b_ack after 4 cycles, rdata unchanged.
REQ-037 Both requesting across 3 slots after reset -> grants A, B, A; ae/be never overlap.
REQ-038 slot_cen pulsed every cycle with a_req high -> accesses exactly every 5 cycles (idle cycle between); overlapping slots ignored.
REQ-039 Reset asserted during STROBE -> all strobes high and ae=be=0 in the same cycle, no ack, next slot_cen grants A.
REQ-040 STROBE_CYCLES=1 and 7 -> strobe widths 1 and 7, ack latencies 3 and 9.
